// File: rtl/sb_param_cfg_shadow.sv
// Parametrised corner switch block with a shadowed configuration chain.
// Bits shift serially through the chain; a counted commit copies them into the live shadow.
module sb_param_cfg_shadow #(
  parameter int unsigned CHAN_W  = 10,
  parameter int unsigned MUX_IN  = 4,
  parameter int unsigned N_PIN   = 2,
  parameter int unsigned SEL_W   = $clog2(MUX_IN),
  parameter int unsigned CFG_LEN = 2 * CHAN_W * SEL_W
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_en,
  input  logic              ccff_head,
  input  logic              cfg_commit,
  input  logic [CHAN_W-1:0] chany_top_in,
  input  logic [CHAN_W-1:0] chanx_right_in,
  input  logic [N_PIN-1:0]  top_pin_in,
  input  logic [N_PIN-1:0]  right_pin_in,
  output logic              ccff_tail,
  output logic              cfg_ready,
  output logic              cfg_active,
  output logic              cfg_err,
  output logic [CHAN_W-1:0] chany_top_out,
  output logic [CHAN_W-1:0] chanx_right_out
);

  localparam int unsigned CntW = $clog2(CFG_LEN + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(CFG_LEN);

  logic [CFG_LEN-1:0] chain_q, chain_d;
  logic [CFG_LEN-1:0] shadow_q, shadow_d;
  logic [CntW-1:0]    count_q, count_d;
  logic               active_q, active_d;
  logic               err_q, err_d;
  logic               full;

  assign full = (count_q == CntFull);

  always_comb begin
    chain_d  = chain_q;
    shadow_d = shadow_q;
    count_d  = count_q;
    active_d = active_q;
    err_d    = err_q;
    if (cfg_en && cfg_commit) begin
      // Ambiguous request: neither shift nor commit, just flag it.
      err_d = 1'b1;
    end else if (cfg_en) begin
      chain_d = {chain_q[CFG_LEN-2:0], ccff_head};
      if (!full) begin
        count_d = count_q + CntW'(1);
      end
    end else if (cfg_commit) begin
      if (full) begin
        shadow_d = chain_q;
        active_d = 1'b1;
        count_d  = '0;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge prog_clk) begin
    if (!pReset) begin
      chain_q  <= '0;
      shadow_q <= '0;
      count_q  <= '0;
      active_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      chain_q  <= chain_d;
      shadow_q <= shadow_d;
      count_q  <= count_d;
      active_q <= active_d;
      err_q    <= err_d;
    end
  end

  assign ccff_tail  = chain_q[CFG_LEN-1];
  assign cfg_ready  = full;
  assign cfg_active = active_q;
  assign cfg_err    = err_q;

  // Each track gathers its MUX_IN candidates with constant indices, then picks one by select.
  for (genvar t = 0; t < CHAN_W; t++) begin : g_track
    logic [MUX_IN-1:0] top_cand;
    logic [MUX_IN-1:0] right_cand;
    logic [SEL_W-1:0]  top_sel;
    logic [SEL_W-1:0]  right_sel;

    assign top_sel       = shadow_q[t*SEL_W +: SEL_W];
    assign right_sel     = shadow_q[(CHAN_W+t)*SEL_W +: SEL_W];
    assign top_cand[0]   = top_pin_in[t % N_PIN];
    assign right_cand[0] = right_pin_in[t % N_PIN];

    for (genvar s = 1; s < MUX_IN; s++) begin : g_in
      assign top_cand[s]   = chanx_right_in[(t + s) % CHAN_W];
      assign right_cand[s] = chany_top_in[(t + s - 1) % CHAN_W];
    end

    // Selects beyond MUX_IN (non-power-of-2 fan-in) route a constant 0.
    assign chany_top_out[t]   = active_q & (32'(top_sel) < MUX_IN) & top_cand[top_sel];
    assign chanx_right_out[t] = active_q & (32'(right_sel) < MUX_IN) & right_cand[right_sel];
  end

endmodule

// File: tb/tb_sb_param_cfg_shadow.sv
// Bench for sb_param_cfg_shadow: directed scenarios plus a randomized run
// against a queue-based behavioural model of the configuration chain.
module tb_sb_param_cfg_shadow;

  localparam int unsigned CHAN_W  = 10;
  localparam int unsigned MUX_IN  = 4;
  localparam int unsigned N_PIN   = 2;
  localparam int unsigned SEL_W   = 2;
  localparam int unsigned CFG_LEN = 40;
  localparam int unsigned OUT_W   = 4 + 2 * CHAN_W;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              cfg_en;
  logic              ccff_head;
  logic              cfg_commit;
  logic [CHAN_W-1:0] chany_top_in;
  logic [CHAN_W-1:0] chanx_right_in;
  logic [N_PIN-1:0]  top_pin_in;
  logic [N_PIN-1:0]  right_pin_in;
  logic              ccff_tail;
  logic              cfg_ready;
  logic              cfg_active;
  logic              cfg_err;
  logic [CHAN_W-1:0] chany_top_out;
  logic [CHAN_W-1:0] chanx_right_out;
  logic [OUT_W-1:0]  dut_outs;

  int errors = 0;
  int checks = 0;

  // Model: index i of each queue is chain/shadow bit i.
  bit          m_chain[$];
  bit          m_shadow[$];
  int unsigned m_count;
  bit          m_active;
  bit          m_err;

  sb_param_cfg_shadow #(
    .CHAN_W (CHAN_W),
    .MUX_IN (MUX_IN),
    .N_PIN  (N_PIN),
    .SEL_W  (SEL_W),
    .CFG_LEN(CFG_LEN)
  ) dut (
    .prog_clk       (prog_clk),
    .pReset         (pReset),
    .cfg_en         (cfg_en),
    .ccff_head      (ccff_head),
    .cfg_commit     (cfg_commit),
    .chany_top_in   (chany_top_in),
    .chanx_right_in (chanx_right_in),
    .top_pin_in     (top_pin_in),
    .right_pin_in   (right_pin_in),
    .ccff_tail      (ccff_tail),
    .cfg_ready      (cfg_ready),
    .cfg_active     (cfg_active),
    .cfg_err        (cfg_err),
    .chany_top_out  (chany_top_out),
    .chanx_right_out(chanx_right_out)
  );

  assign dut_outs = {ccff_tail, cfg_ready, cfg_active, cfg_err, chany_top_out, chanx_right_out};

  always #5 prog_clk = ~prog_clk;

  task automatic model_clear();
    m_chain.delete();
    m_shadow.delete();
    for (int i = 0; i < int'(CFG_LEN); i++) begin
      m_chain.push_back(1'b0);
      m_shadow.push_back(1'b0);
    end
    m_count  = 0;
    m_active = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_update();
    if (!pReset) begin
      model_clear();
    end else if (cfg_en && cfg_commit) begin
      m_err = 1'b1;
    end else if (cfg_en) begin
      m_chain.push_front(ccff_head);
      void'(m_chain.pop_back());
      if (m_count < CFG_LEN) m_count++;
    end else if (cfg_commit) begin
      if (m_count == CFG_LEN) begin
        m_shadow = m_chain;
        m_active = 1'b1;
        m_count  = 0;
      end else begin
        m_err = 1'b1;
      end
    end
  endtask

  function automatic int unsigned field(int unsigned j);
    int unsigned v = 0;
    for (int unsigned b = 0; b < SEL_W; b++) begin
      if (m_shadow[j * SEL_W + b]) v += (32'd1 << b);
    end
    return v;
  endfunction

  function automatic logic [CHAN_W-1:0] model_top();
    logic [CHAN_W-1:0] r = '0;
    for (int unsigned t = 0; t < CHAN_W; t++) begin
      int unsigned s;
      bit          b;
      s = field(t);
      b = 1'b0;
      if (m_active) begin
        if (s == 0) b = 1'(top_pin_in >> (t % N_PIN));
        else if (s < MUX_IN) b = 1'(chanx_right_in >> ((t + s) % CHAN_W));
      end
      r |= CHAN_W'(b) << t;
    end
    return r;
  endfunction

  function automatic logic [CHAN_W-1:0] model_right();
    logic [CHAN_W-1:0] r = '0;
    for (int unsigned t = 0; t < CHAN_W; t++) begin
      int unsigned s;
      bit          b;
      s = field(CHAN_W + t);
      b = 1'b0;
      if (m_active) begin
        if (s == 0) b = 1'(right_pin_in >> (t % N_PIN));
        else if (s < MUX_IN) b = 1'(chany_top_in >> ((t + s - 1) % CHAN_W));
      end
      r |= CHAN_W'(b) << t;
    end
    return r;
  endfunction

  function automatic logic [OUT_W-1:0] model_outs();
    return {m_chain[CFG_LEN-1], (m_count == CFG_LEN), m_active, m_err, model_top(), model_right()};
  endfunction

  task automatic tick();
    @(posedge prog_clk);
    model_update();
    #1;
  endtask

  task automatic shift_bit(input bit b);
    cfg_en    = 1'b1;
    ccff_head = b;
    tick();
    cfg_en    = 1'b0;
  endtask

  task automatic load_vec(input logic [CFG_LEN-1:0] v);
    for (int i = int'(CFG_LEN) - 1; i >= 0; i--) shift_bit(v[i]);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  task automatic randomize_chans();
    chany_top_in   = CHAN_W'($urandom);
    chanx_right_in = CHAN_W'($urandom);
    top_pin_in     = N_PIN'($urandom);
    right_pin_in   = N_PIN'($urandom);
  endtask

  task automatic test_reset();
    pReset = 1'b0;
    tick();
    tick();
    pReset = 1'b1;
    randomize_chans();
    tick();
    checks++;
    if (dut_outs !== '0) begin
      errors++;
      $display("FAIL reset_idle: got %h expected %h", dut_outs, {OUT_W{1'b0}});
    end
    checks++;
    if (dut_outs !== model_outs()) begin
      errors++;
      $display("FAIL reset_model: got %h expected %h", dut_outs, model_outs());
    end
  endtask

  task automatic test_zero_load();
    load_vec('0);
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero_ready_full: got %b expected 1", cfg_ready);
    end
    commit();
    checks++;
    if ({cfg_active, cfg_ready} !== 2'b10) begin
      errors++;
      $display("FAIL zero_commit_flags: got %b expected 10", {cfg_active, cfg_ready});
    end
    top_pin_in   = 2'b01;
    right_pin_in = 2'b10;
    #1;
    checks++;
    if (chany_top_out !== 10'b0101010101) begin
      errors++;
      $display("FAIL zero_top_pins: got %b expected 0101010101", chany_top_out);
    end
    checks++;
    if (chanx_right_out !== 10'b1010101010) begin
      errors++;
      $display("FAIL zero_right_pins: got %b expected 1010101010", chanx_right_out);
    end
  endtask

  task automatic test_sel_one();
    load_vec({20{2'b01}});
    commit();
    top_pin_in     = '0;
    right_pin_in   = '0;
    chany_top_in   = '0;
    chanx_right_in = 10'b0000000010;
    #1;
    checks++;
    if (chany_top_out !== 10'b0000000001) begin
      errors++;
      $display("FAIL sel1_top: got %b expected 0000000001", chany_top_out);
    end
    chanx_right_in = '0;
    chany_top_in   = 10'b0000001000;
    #1;
    checks++;
    if (chanx_right_out !== 10'b0000001000) begin
      errors++;
      $display("FAIL sel1_right: got %b expected 0000001000", chanx_right_out);
    end
    for (int i = 0; i < 4; i++) begin
      randomize_chans();
      #1;
      checks++;
      if (dut_outs !== model_outs()) begin
        errors++;
        $display("FAIL sel1_random: got %h expected %h", dut_outs, model_outs());
      end
    end
  endtask

  task automatic test_short_commit();
    logic [2*CHAN_W-1:0] saved;
    randomize_chans();
    saved = {model_top(), model_right()};
    for (int i = 0; i < 39; i++) shift_bit(1'($urandom));
    commit();
    checks++;
    if ({cfg_err, cfg_ready, cfg_active} !== 3'b101) begin
      errors++;
      $display("FAIL short_flags: got %b expected 101", {cfg_err, cfg_ready, cfg_active});
    end
    checks++;
    if ({chany_top_out, chanx_right_out} !== saved) begin
      errors++;
      $display("FAIL short_route_kept: got %h expected %h", {chany_top_out, chanx_right_out}, saved);
    end
    shift_bit(1'($urandom));
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL short_count_39: got ready %b expected 1", cfg_ready);
    end
    commit();
    checks++;
    if (dut_outs !== model_outs() || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL short_recommit: got %h expected %h", dut_outs, model_outs());
    end
  endtask

  task automatic test_overflow();
    logic [2*CHAN_W-1:0] saved;
    bit                  pat[45];
    randomize_chans();
    saved = {model_top(), model_right()};
    for (int k = 0; k < 45; k++) pat[k] = 1'($urandom);
    for (int k = 1; k <= 45; k++) begin
      shift_bit(pat[k-1]);
      if (k >= 40 && k <= 44) begin
        checks++;
        if (ccff_tail !== pat[k-40] || cfg_ready !== 1'b1) begin
          errors++;
          $display("FAIL overflow_tail: shift %0d got tail %b ready %b expected tail %b ready 1",
                   k, ccff_tail, cfg_ready, pat[k-40]);
        end
      end
      checks++;
      if ({chany_top_out, chanx_right_out} !== saved) begin
        errors++;
        $display("FAIL overflow_route_held: got %h expected %h",
                 {chany_top_out, chanx_right_out}, saved);
      end
    end
    commit();
    randomize_chans();
    #1;
    checks++;
    if (dut_outs !== model_outs()) begin
      errors++;
      $display("FAIL overflow_commit: got %h expected %h", dut_outs, model_outs());
    end
  endtask

  task automatic test_reset_mid_shift();
    for (int i = 0; i < 20; i++) shift_bit(1'($urandom));
    pReset = 1'b0;
    cfg_en = 1'b1;
    tick();
    cfg_en = 1'b0;
    pReset = 1'b1;
    randomize_chans();
    #1;
    checks++;
    if (dut_outs !== '0) begin
      errors++;
      $display("FAIL midreset_clear: got %h expected %h", dut_outs, {OUT_W{1'b0}});
    end
    load_vec({$urandom, $urandom});
    commit();
    for (int i = 0; i < 4; i++) begin
      randomize_chans();
      #1;
      checks++;
      if (dut_outs !== model_outs()) begin
        errors++;
        $display("FAIL midreset_reload: got %h expected %h", dut_outs, model_outs());
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 5; i++) shift_bit(1'($urandom));
    cfg_en     = 1'b1;
    cfg_commit = 1'b1;
    ccff_head  = ~m_chain[0];
    tick();
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
    checks++;
    if (dut_outs !== model_outs() || cfg_err !== 1'b1) begin
      errors++;
      $display("FAIL both_en_commit: got %h expected %h", dut_outs, model_outs());
    end
    // Tail proves the chain did not move on the ambiguous cycle.
    for (int i = 0; i < 35; i++) begin
      shift_bit(1'($urandom));
      checks++;
      if (ccff_tail !== m_chain[CFG_LEN-1] || cfg_ready !== (m_count == CFG_LEN)) begin
        errors++;
        $display("FAIL both_chain_hold: got %b%b expected %b%b", ccff_tail, cfg_ready,
                 m_chain[CFG_LEN-1], (m_count == CFG_LEN));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      pReset     = ($urandom_range(199) != 0);
      cfg_en     = ($urandom_range(3) != 0);
      cfg_commit = ($urandom_range(14) == 0);
      ccff_head  = 1'($urandom);
      randomize_chans();
      tick();
      checks++;
      if (dut_outs !== model_outs()) begin
        errors++;
        $display("FAIL random_cycle %0d: got %h expected %h", i, dut_outs, model_outs());
      end
    end
    pReset     = 1'b1;
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
  endtask

  initial begin
    pReset     = 1'b0;
    cfg_en     = 1'b0;
    cfg_commit = 1'b0;
    ccff_head  = 1'b0;
    randomize_chans();
    model_clear();
    #2;
    test_reset();
    test_zero_load();
    test_sel_one();
    test_short_commit();
    test_overflow();
    test_reset_mid_shift();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sb_param_cfg_shadow.md
Name: sb_param_cfg_shadow

Overview:
- Parametrised successor of the fixed size-2 unique switch block.
- Routes top (chany) and right (chanx) channel tracks of configurable width W through per-track muxes of configurable fan-in.
- The configuration chain is shadowed: bits shift serially from ccff_head to ccff_tail without disturbing live routing. A counted commit transfers them atomically to the active configuration.
- Sits at corner SB positions in the routing fabric, chained into the global configuration chain.

Parameters:
- CHAN_W, 10, tracks per channel side (W ≥ 2)
- MUX_IN, 4, inputs per track mux (2..16)
- N_PIN, 2, grid pins per side feeding mux input 0 (≥ 1)
- SEL_W, $clog2(MUX_IN), derived: config bits per mux
- CFG_LEN, 2*CHAN_W*SEL_W, derived: shift-chain length (default 40)

Ports:
- prog_clk  in  1  programming/config clock
- pReset  in  1  synchronous, active-low reset
- cfg_en  in  1  shift enable: one chain bit per cycle
- ccff_head  in  1  serial configuration input
- cfg_commit  in  1  single-cycle request to copy chain into shadow
- chany_top_in  in  CHAN_W  top-side incoming tracks
- chanx_right_in  in  CHAN_W  right-side incoming tracks
- top_pin_in  in  N_PIN  grid pins for top muxes
- right_pin_in  in  N_PIN  grid pins for right muxes
- ccff_tail  out  1  serial configuration output, chain[CFG_LEN-1]
- cfg_ready  out  1  high when bit count == CFG_LEN
- cfg_active  out  1  shadow holds a committed configuration
- cfg_err  out  1  sticky: illegal commit seen
- chany_top_out  out  CHAN_W  top-side outgoing tracks
- chanx_right_out  out  CHAN_W  right-side outgoing tracks

Behaviour:
- Clock and reset: single clock prog_clk; pReset is synchronous, active-low. All state updates on the rising edge of prog_clk.
- Reset (pReset = 0 at the edge): chain, shadow and count are cleared to 0, as are cfg_active and cfg_err. Consequently ccff_tail = 0, cfg_ready = 0, and all track outputs = 0. Reset overrides cfg_en and cfg_commit, including mid-shift.
- Shift (cfg_en = 1, cfg_commit = 0):
  - chain[0] <= ccff_head; chain[i] <= chain[i-1].
  - count increments, saturating at CFG_LEN.
  - Shifting past CFG_LEN is legal: old bits flush out ccff_tail and count stays at CFG_LEN.
- Field map: mux j uses chain[j*SEL_W +: SEL_W], LSB at the lower index.
  - j = 0..W-1 drives chany_top_out[j].
  - j = W..2W-1 drives chanx_right_out[j-W].
  - The first bit shifted in lands at index CFG_LEN-1.
- Commit (cfg_commit = 1, cfg_en = 0):
  - If count == CFG_LEN: shadow <= chain, cfg_active <= 1, count <= 0. The chain is retained.
  - Otherwise: cfg_err <= 1; shadow, count and cfg_active are unchanged.
- Simultaneous cfg_en and cfg_commit: no shift, no commit, cfg_err <= 1.
- cfg_err clears only on reset.
- Routing (combinational from shadow and inputs; new config visible the cycle after the commit edge):
  - Top track t, select s:
    - s = 0: top_pin_in[t mod N_PIN]
    - 1 ≤ s < MUX_IN: chanx_right_in[(t+s) mod W]
  - Right track t, select s:
    - s = 0: right_pin_in[t mod N_PIN]
    - 1 ≤ s < MUX_IN: chany_top_in[(t+s-1) mod W]
  - s ≥ MUX_IN (non-power-of-2 MUX_IN): output 0.
  - While cfg_active = 0, all track outputs = 0.
- Live routing never changes during shifting; it changes only on a successful commit.
- ccff_tail is registered (chain MSB), giving CFG_LEN cycles head-to-tail latency.

Test Plan:
- Reset then idle → all outputs 0, cfg_ready = 0, cfg_active = 0, ccff_tail = 0.
- Shift 40 bits all 0, commit → cfg_active = 1, cfg_ready drops next cycle. Drive top_pin_in = 2'b01, right_pin_in = 2'b10 → chany_top_out = 10'b0101010101 (bit t = top_pin_in[t mod 2]), chanx_right_out = 10'b1010101010.
- Load select 1 for every mux, commit, chanx_right_in = 10'b0000000010 → chany_top_out[0] = 1 and all other bits 0. Then chany_top_in = 10'b0000001000 → chanx_right_out[3] = 1.
- Commit after only 39 shifted bits → cfg_err = 1, outputs keep previous routing, count is still 39. One more shift then commit → succeeds, cfg_err stays 1.
- Shift a 45-bit pattern → ccff_tail emits the first 5 bits on cycles 41–45 of shifting and cfg_ready stays 1. Outputs remain unchanged throughout until commit.
- Assert pReset low mid-shift at bit 20 → count = 0, cfg_active = 0, outputs 0. A fresh 40-bit load plus commit then works normally.
